multibit_serial_adder: RTL and testbench
========================================

// Module: multibit_serial_adder
// PURPOSE
// - Parametrised multi-cycle adder: adds two WIDTH-bit operands DIGIT bits per clock, LSB first.
// - Registered carry chains between beats; start/busy/done handshake.
// - Drop-in for arithmetic paths where area matters more than latency.
// - Reports sum, carry-out and signed overflow.
// PARAMETERS
// - WIDTH  8  operand/result width in bits (>=2)
// - DIGIT  1  bits added per clock; WIDTH % DIGIT must be 0, else $error at elaboration
// PORTS
// - clk_in        in   1      single clock, rising edge
// - rst_in        in   1      synchronous reset, active-high
// - start_in      in   1      request; sampled only in IDLE
// - a_in          in   WIDTH  operand A, captured with start
// - b_in          in   WIDTH  operand B, captured with start
// - carry_in      in   1      carry into bit 0, captured with start
// - busy_out      out  1      high while state != IDLE
// - done_out      out  1      one-cycle pulse: result valid
// - sum_out       out  WIDTH  result; held until next done
// - carry_out     out  1      carry out of bit WIDTH-1
// - overflow_out  out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
// - Reset: state IDLE; busy_out, done_out, sum_out, carry_out, overflow_out all 0; internal shift regs/counter 0.
// - Reset wins over every other event, including mid-operation: operation aborted, no done pulse.
// - N = WIDTH/DIGIT beats. FSM states: IDLE, RUN, DONE.
// - IDLE: start_in=1 at edge t -> load A, B, carry regs; cnt=0; -> RUN. Else stay.
// - RUN: each edge adds low DIGIT bits of A/B + carry reg; shifts A/B right by DIGIT.
// - RUN: shifts result digit into sum shift reg from MSB end; updates carry reg; cnt++.
// - RUN: at edge t+N (cnt==N-1) -> DONE; sum_out, carry_out, overflow_out loaded; done_out=1.
// - DONE: lasts exactly one cycle; next edge -> IDLE, done_out=0.
// - Latency: done_out high in the cycle after edge t+N; back-to-back throughput one op per N+2 cycles.
// - start_in in RUN or DONE ignored; captured operands unaffected.
// - a_in/b_in/carry_in changes after capture have no effect.
// - Arithmetic: unsigned modulo 2^WIDTH; carry_out = bit WIDTH of A+B+cin.
// - Overflow needs carry into MSB: retained from the final beat's per-bit chain.
// - sum_out/carry_out/overflow_out change only at the DONE entry edge or reset.
// - DIGIT==WIDTH legal: N=1, done one cycle after RUN entry.
// CONFIGURATION
// - Macro SERIAL_ADDER_SUB_EN.
// - Defined: extra port sub_in (in, 1), captured with start.
// - sub_in=1: computes A-B; B inverted and initial carry forced to 1, carry_in ignored; carry_out=1 means no borrow.
// - sub_in=1: overflow_out follows the same MSB carry rule.
// - Not defined: no sub_in port; add only; logic identical to sub_in=0.
// TESTING
// - Reset: assert rst_in 2 cycles -> all outputs 0, busy_out 0.
// - WIDTH=8,DIGIT=1: a=35h,b=4Ah,cin=0,start -> done 8 cycles after start edge; sum=7Fh,carry=0,ovf=0.
// - WIDTH=8,DIGIT=1: a=FFh,b=01h,cin=0 -> sum=00h,carry=1,ovf=0.
// - WIDTH=8,DIGIT=1: a=7Fh,b=01h -> sum=80h,carry=0,ovf=1.
// - a=7Fh,b=01h: change a_in to 00h after capture -> sum still 80h.
// - start=1 held across busy -> second capture only in IDLE after DONE; exactly one done per op.
// - rst_in at beat 4 -> busy 0 next cycle, no done pulse, sum_out=00h.
// - WIDTH=8,DIGIT=4: a=FFh,b=FFh,cin=1 -> done 2 cycles after start; sum=FFh,carry=1,ovf=0.
// - SERIAL_ADDER_SUB_EN defined: a=10h,b=20h,sub=1 -> sum=F0h,carry=0,ovf=0.
// - SERIAL_ADDER_SUB_EN defined: a=80h,b=01h,sub=1 -> sum=7Fh,carry=1,ovf=1.

Source files
------------

// File: rtl/multibit_serial_adder.sv
// rtl/multibit_serial_adder.sv - digit-serial adder, LSB first, with start/busy/done handshake
// Optional macro SERIAL_ADDER_SUB_EN adds sub_in for A-B (B inverted, carry forced to 1).
module multibit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_in,
`endif
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow_out
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_params
      $error("multibit_serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 r_state;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic [WIDTH-1:0]       r_sum_sh;
  logic                   r_carry;
  logic [CW-1:0]          r_cnt;

  logic [DIGIT-1:0]       w_dig_sum;
  logic                   w_dig_cout;
  logic                   w_msb_cin;
  logic                   w_c;
  logic [WIDTH+DIGIT-1:0] w_cat;
  logic [WIDTH-1:0]       w_sum_next;
  logic                   w_sub;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub = sub_in;
`else
  assign w_sub = 1'b0;
`endif

  // Ripple through one digit; the carry into the digit's top bit is kept so the
  // final beat yields the carry into the operand MSB for overflow detection.
  always_comb begin
    w_c       = r_carry;
    w_dig_sum = '0;
    w_msb_cin = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      w_msb_cin    = w_c;
      w_dig_sum[i] = r_a[i] ^ r_b[i] ^ w_c;
      w_c          = (r_a[i] & r_b[i]) | (w_c & (r_a[i] ^ r_b[i]));
    end
    w_dig_cout = w_c;
  end

  assign w_cat      = {w_dig_sum, r_sum_sh};
  assign w_sum_next = w_cat[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_sum_sh     <= '0;
      r_carry      <= 1'b0;
      r_cnt        <= '0;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
      sum_out      <= '0;
      carry_out    <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done_out <= 1'b0;
          if (start_in) begin
            r_a      <= a_in;
            r_b      <= w_sub ? ~b_in : b_in;
            r_carry  <= w_sub ? 1'b1 : carry_in;
            r_sum_sh <= '0;
            r_cnt    <= '0;
            busy_out <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_a      <= r_a >> DIGIT;
          r_b      <= r_b >> DIGIT;
          r_sum_sh <= w_sum_next;
          r_carry  <= w_dig_cout;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CW'(N - 1)) begin
            sum_out      <= w_sum_next;
            carry_out    <= w_dig_cout;
            overflow_out <= w_dig_cout ^ w_msb_cin;
            done_out     <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          done_out <= 1'b0;
          busy_out <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          done_out <= 1'b0;
          busy_out <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multibit_serial_adder.sv
// tb/tb_multibit_serial_adder.sv - scoreboard bench for multibit_serial_adder, DIGIT=1 and DIGIT=4
module tb_multibit_serial_adder;
  logic       clk;
  logic       rst;
  logic       start;
  logic       sel;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
`endif

  logic       d1_busy, d1_done, d1_carry, d1_ovf;
  logic [7:0] d1_sum;
  logic       d4_busy, d4_done, d4_carry, d4_ovf;
  logic [7:0] d4_sum;
  logic       start1, start4;
  logic       w_busy, w_done, w_carry, w_ovf;
  logic [7:0] w_sum;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [9:0] sb_q[$];

  assign start1  = start & ~sel;
  assign start4  = start & sel;
  assign w_busy  = sel ? d4_busy  : d1_busy;
  assign w_done  = sel ? d4_done  : d1_done;
  assign w_sum   = sel ? d4_sum   : d1_sum;
  assign w_carry = sel ? d4_carry : d1_carry;
  assign w_ovf   = sel ? d4_ovf   : d1_ovf;

  multibit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk_in(clk), .rst_in(rst), .start_in(start1),
    .a_in(a_in), .b_in(b_in), .carry_in(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_in(sub),
`endif
    .busy_out(d1_busy), .done_out(d1_done), .sum_out(d1_sum),
    .carry_out(d1_carry), .overflow_out(d1_ovf)
  );

  multibit_serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk_in(clk), .rst_in(rst), .start_in(start4),
    .a_in(a_in), .b_in(b_in), .carry_in(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_in(sub),
`endif
    .busy_out(d4_busy), .done_out(d4_done), .sum_out(d4_sum),
    .carry_out(d4_carry), .overflow_out(d4_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic c, input logic sb);
    logic [8:0] full;
    logic       ov;
    if (sb) begin
      full = {1'b0, a} - {1'b0, b};
      full[8] = (a >= b);
      ov = (a[7] != b[7]) && (full[7] != a[7]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {8'd0, c};
      ov = (a[7] == b[7]) && (full[7] != a[7]);
    end
    return {ov, full[8], full[7:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sel = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({d1_busy, d1_done, d1_carry, d1_ovf, d1_sum} !== 12'h000)
      $display("FAIL reset_d1: got busy=%0b done=%0b carry=%0b ovf=%0b sum=%02h, expected all 0",
               d1_busy, d1_done, d1_carry, d1_ovf, d1_sum);
    else pass_cnt++;
    total_cnt++;
    if ({d4_busy, d4_done, d4_carry, d4_ovf, d4_sum} !== 12'h000)
      $display("FAIL reset_d4: got busy=%0b done=%0b carry=%0b ovf=%0b sum=%02h, expected all 0",
               d4_busy, d4_done, d4_carry, d4_ovf, d4_sum);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_op(input string name, input logic s, input logic [7:0] a,
                         input logic [7:0] b, input logic c, input logic sb,
                         input logic chg, input int exp_lat);
    logic [9:0] e;
    int         lat;
    logic       got;
    sb_q.push_back(model(a, b, c, sb));
    @(posedge clk); #1;
    sel = s; a_in = a; b_in = b; cin = c; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = sb;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    if (chg) begin
      a_in = 8'h00; b_in = ~b; cin = ~c;
`ifdef SERIAL_ADDER_SUB_EN
      sub = ~sb;
`endif
    end
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (w_done) got = 1'b1;
    end
    total_cnt++;
    if (!got || lat != exp_lat)
      $display("FAIL %s latency: got %0d cycles (done seen=%0b), expected %0d", name, lat, got, exp_lat);
    else pass_cnt++;
    e = sb_q.pop_front();
    total_cnt++;
    if (w_sum !== e[7:0]) $display("FAIL %s sum: got %02h expected %02h", name, w_sum, e[7:0]);
    else pass_cnt++;
    total_cnt++;
    if ({w_ovf, w_carry} !== e[9:8])
      $display("FAIL %s carry/ovf: got carry=%0b ovf=%0b expected carry=%0b ovf=%0b",
               name, w_carry, w_ovf, e[8], e[9]);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (w_done !== 1'b0 || w_busy !== 1'b0 || w_sum !== e[7:0])
      $display("FAIL %s after_done: got done=%0b busy=%0b sum=%02h expected done=0 busy=0 sum=%02h",
               name, w_done, w_busy, w_sum, e[7:0]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int         done_k[$];
    logic [9:0] e;
    sel = 1'b0;
    sb_q.push_back(model(8'h12, 8'h34, 1'b0, 1'b0));
    sb_q.push_back(model(8'h12, 8'h34, 1'b0, 1'b0));
    @(posedge clk); #1;
    a_in = 8'h12; b_in = 8'h34; cin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 12) start = 1'b0;
      @(negedge clk);
      if (d1_done) begin
        done_k.push_back(k);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 10'h3ff;
        total_cnt++;
        if (d1_sum !== e[7:0]) $display("FAIL b2b sum: got %02h expected %02h", d1_sum, e[7:0]);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (done_k.size() != 2 || done_k[0] != 9 || done_k[1] != 19)
      $display("FAIL b2b done_count: got %0d pulses (first at %0d), expected 2 at cycles 9 and 19",
               done_k.size(), (done_k.size() > 0) ? done_k[0] : -1);
    else pass_cnt++;
    sb_q.delete();
  endtask

  task automatic test_reset_mid();
    int dones;
    sel = 1'b0;
    @(posedge clk); #1;
    a_in = 8'h35; b_in = 8'h4a; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (d1_busy !== 1'b0 || d1_sum !== 8'h00 || d1_done !== 1'b0)
      $display("FAIL reset_mid state: got busy=%0b done=%0b sum=%02h expected busy=0 done=0 sum=00",
               d1_busy, d1_done, d1_sum);
    else pass_cnt++;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (d1_done) dones++;
    end
    total_cnt++;
    if (dones != 0) $display("FAIL reset_mid no_done: got %0d done pulses expected 0", dones);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_op("add_35_4a",   1'b0, 8'h35, 8'h4a, 1'b0, 1'b0, 1'b0, 8);
    test_op("add_ff_01",   1'b0, 8'hff, 8'h01, 1'b0, 1'b0, 1'b0, 8);
    test_op("add_7f_01",   1'b0, 8'h7f, 8'h01, 1'b0, 1'b0, 1'b0, 8);
    test_op("capture",     1'b0, 8'h7f, 8'h01, 1'b0, 1'b0, 1'b1, 8);
    test_op("add_cin",     1'b0, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 8);
    test_back_to_back();
    test_reset_mid();
    test_op("d4_ff_ff_c1", 1'b1, 8'hff, 8'hff, 1'b1, 1'b0, 1'b0, 2);
    test_op("d4_35_4a",    1'b1, 8'h35, 8'h4a, 1'b0, 1'b0, 1'b1, 2);
    test_op("d4_40_40",    1'b1, 8'h40, 8'h40, 1'b0, 1'b0, 1'b0, 2);
`ifdef SERIAL_ADDER_SUB_EN
    test_op("sub_10_20",   1'b0, 8'h10, 8'h20, 1'b1, 1'b1, 1'b0, 8);
    test_op("sub_80_01",   1'b0, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 8);
    test_op("d4_sub_80_01", 1'b1, 8'h80, 8'h01, 1'b1, 1'b1, 1'b1, 2);
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
